// File: rtl/tag_compare_assoc_pkg.sv
// Shared definitions for the set-associative tag compare block.
// Holds the parameter defaults, the per-way metadata field layout and the
// controller state encoding.
package tag_compare_assoc_pkg;

  localparam int unsigned DEF_ADDR_WIDTH   = 32;
  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_TID_WIDTH    = 4;
  localparam int unsigned DEF_INDEX_WIDTH  = 6;
  localparam int unsigned DEF_OFFSET_WIDTH = 4;
  localparam int unsigned DEF_WAYS         = 4;

  // Per-way metadata entry is {valid, dirty, tag}; tag sits in the LSBs.
  localparam int unsigned META_TAG_LSB = 0;

  function automatic int unsigned meta_dirty_pos(input int unsigned tag_w);
    return tag_w;
  endfunction

  function automatic int unsigned meta_valid_pos(input int unsigned tag_w);
    return tag_w + 1;
  endfunction

  // A way index needs at least one bit, even for a direct-mapped cache.
  function automatic int unsigned way_idx_width(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMP   = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

endpackage

// File: rtl/tag_compare_assoc_way_select.sv
// Hit detection and victim selection.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   valid_i       : per-way valid bits
//   tags_i        : per-way tags, way 0 in the LSBs
//   cmp_tag_i     : tag field of the request address
//   update_i      : compare cycle strobe; lets the round-robin pointer move
//   hit_o         : at least one way hits
//   multihit_o    : more than one way hits
//   hit_way_o     : lowest-numbered hitting way
//   victim_way_o  : lowest invalid way, else the round-robin pointer
module tag_compare_assoc_way_select
  import tag_compare_assoc_pkg::*;
#(
  parameter int unsigned WAYS      = DEF_WAYS,
  parameter int unsigned TAG_WIDTH = 22,
  localparam int unsigned WAY_W    = way_idx_width(WAYS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WAYS-1:0]           valid_i,
  input  logic [WAYS*TAG_WIDTH-1:0] tags_i,
  input  logic [TAG_WIDTH-1:0]      cmp_tag_i,
  input  logic                      update_i,
  output logic                      hit_o,
  output logic                      multihit_o,
  output logic [WAY_W-1:0]          hit_way_o,
  output logic [WAY_W-1:0]          victim_way_o
);

  logic [WAYS-1:0]  hit_vec;
  logic             all_valid;
  logic [WAY_W-1:0] rr_q, rr_d;

  always_comb begin
    hit_vec = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_i[w] && (tags_i[w*TAG_WIDTH +: TAG_WIDTH] == cmp_tag_i);
    end
    hit_o      = |hit_vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multihit_o = (hit_vec & (hit_vec - WAYS'(1))) != '0;
    all_valid  = &valid_i;

    // Downward scans so the lowest-numbered candidate is written last.
    hit_way_o    = '0;
    victim_way_o = rr_q;
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (hit_vec[w-1]) hit_way_o = WAY_W'(w - 1);
      if (!valid_i[w-1]) victim_way_o = WAY_W'(w - 1);
    end

    rr_d = rr_q;
    if (update_i && !hit_o && all_valid) begin
      rr_d = (rr_q == WAY_W'(WAYS - 1)) ? '0 : rr_q + WAY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end

endmodule

// File: rtl/tag_compare_assoc.sv
// Set-associative tag compare and request dispatch.
// Accepts a request together with its tag-read response, compares tags for
// one cycle, then issues the resulting transactions:
//   rob  : read-hit data {tid, line}
//   ar   : miss fetch {tid, line-aligned addr}
//   wb   : dirty-victim writeback {victim addr, victim line}
//   fill : cache update for writes {addr, way, data, dirty=1}
// Each issue channel holds valid/data until its own ready.
// hit_cnt_o / miss_cnt_o are saturating; multihit_err_o is sticky until reset.
module tag_compare_assoc
  import tag_compare_assoc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned TID_WIDTH    = DEF_TID_WIDTH,
  parameter int unsigned INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int unsigned OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int unsigned WAYS         = DEF_WAYS,
  localparam int unsigned TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  localparam int unsigned WAY_W       = way_idx_width(WAYS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic                              req_write_i,
  input  logic [TID_WIDTH-1:0]              req_tid_i,
  input  logic [ADDR_WIDTH-1:0]             req_addr_i,
  input  logic [DATA_WIDTH-1:0]             req_wdata_i,
  input  logic                              meta_valid_i,
  output logic                              meta_ready_o,
  input  logic [WAYS*(2+TAG_WIDTH)-1:0]     meta_i,
  input  logic [WAYS*DATA_WIDTH-1:0]        line_i,
  output logic                              rob_valid_o,
  input  logic                              rob_ready_i,
  output logic [TID_WIDTH+DATA_WIDTH-1:0]   rob_data_o,
  output logic                              ar_valid_o,
  input  logic                              ar_ready_i,
  output logic [TID_WIDTH+ADDR_WIDTH-1:0]   ar_data_o,
  output logic                              wb_valid_o,
  input  logic                              wb_ready_i,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0]  wb_data_o,
  output logic                              fill_valid_o,
  input  logic                              fill_ready_i,
  output logic [ADDR_WIDTH+WAY_W+DATA_WIDTH:0] fill_data_o,
  output logic [31:0]                       hit_cnt_o,
  output logic [31:0]                       miss_cnt_o,
  output logic                              multihit_err_o
);

  localparam int unsigned MW   = 2 + TAG_WIDTH;
  localparam int unsigned DPOS = meta_dirty_pos(TAG_WIDTH);
  localparam int unsigned VPOS = meta_valid_pos(TAG_WIDTH);

  state_e state_q, state_d;

  logic                             write_q, write_d;
  logic [TID_WIDTH-1:0]             tid_q, tid_d;
  logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0]            wdata_q, wdata_d;
  logic [WAYS*MW-1:0]               meta_q, meta_d;
  logic [WAYS*DATA_WIDTH-1:0]       line_q, line_d;

  logic rob_pend_q, rob_pend_d, ar_pend_q, ar_pend_d;
  logic wb_pend_q, wb_pend_d, fill_pend_q, fill_pend_d;
  logic [TID_WIDTH+DATA_WIDTH-1:0]      rob_data_q, rob_data_d;
  logic [TID_WIDTH+ADDR_WIDTH-1:0]      ar_data_q, ar_data_d;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic [ADDR_WIDTH+WAY_W+DATA_WIDTH:0] fill_data_q, fill_data_d;
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        multihit_q, multihit_d;

  logic [WAYS-1:0]           valid_vec;
  logic [WAYS*TAG_WIDTH-1:0] tags_flat;
  logic                      ws_hit, ws_multi;
  logic [WAY_W-1:0]          ws_hit_way, ws_victim;
  logic [MW-1:0]             vic_meta;
  logic                      vic_dirty;
  logic [DATA_WIDTH-1:0]     hit_line, vic_line;
  logic [ADDR_WIDTH-1:0]     line_addr, wb_addr;
  logic                      accept, in_cmp, issue_done;

  always_comb begin
    valid_vec = '0;
    tags_flat = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      valid_vec[w] = meta_q[w*MW + VPOS];
      tags_flat[w*TAG_WIDTH +: TAG_WIDTH] = meta_q[w*MW + META_TAG_LSB +: TAG_WIDTH];
    end
  end

  assign in_cmp = (state_q == S_CMP);
  assign accept = (state_q == S_IDLE) && req_valid_i && meta_valid_i;

  tag_compare_assoc_way_select #(
    .WAYS      (WAYS),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_way_select (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_vec),
    .tags_i       (tags_flat),
    .cmp_tag_i    (addr_q[ADDR_WIDTH-1 -: TAG_WIDTH]),
    .update_i     (in_cmp),
    .hit_o        (ws_hit),
    .multihit_o   (ws_multi),
    .hit_way_o    (ws_hit_way),
    .victim_way_o (ws_victim)
  );

  always_comb begin
    vic_meta  = meta_q[ws_victim*MW +: MW];
    // An invalid way never needs writing back, whatever its dirty bit says.
    vic_dirty = vic_meta[VPOS] && vic_meta[DPOS];
    vic_line  = line_q[ws_victim*DATA_WIDTH +: DATA_WIDTH];
    hit_line  = line_q[ws_hit_way*DATA_WIDTH +: DATA_WIDTH];
    line_addr = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    wb_addr   = {vic_meta[META_TAG_LSB +: TAG_WIDTH],
                 addr_q[OFFSET_WIDTH +: INDEX_WIDTH], {OFFSET_WIDTH{1'b0}}};
  end

  // Datapath: capture, decision, and per-channel completion.
  always_comb begin
    write_d     = write_q;
    tid_d       = tid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    meta_d      = meta_q;
    line_d      = line_q;
    rob_pend_d  = rob_pend_q;
    ar_pend_d   = ar_pend_q;
    wb_pend_d   = wb_pend_q;
    fill_pend_d = fill_pend_q;
    rob_data_d  = rob_data_q;
    ar_data_d   = ar_data_q;
    wb_data_d   = wb_data_q;
    fill_data_d = fill_data_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    multihit_d  = multihit_q | (in_cmp && ws_multi);

    if (accept) begin
      write_d = req_write_i;
      tid_d   = req_tid_i;
      addr_d  = req_addr_i;
      wdata_d = req_wdata_i;
      meta_d  = meta_i;
      line_d  = line_i;
    end

    if (in_cmp) begin
      if (ws_hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
        if (write_q) begin
          fill_pend_d = 1'b1;
          fill_data_d = {addr_q, ws_hit_way, wdata_q, 1'b1};
        end else begin
          rob_pend_d = 1'b1;
          rob_data_d = {tid_q, hit_line};
        end
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
        if (write_q) begin
          fill_pend_d = 1'b1;
          fill_data_d = {addr_q, ws_victim, wdata_q, 1'b1};
        end else begin
          ar_pend_d = 1'b1;
          ar_data_d = {tid_q, line_addr};
        end
        if (vic_dirty) begin
          wb_pend_d = 1'b1;
          wb_data_d = {wb_addr, vic_line};
        end
      end
    end

    if (state_q == S_ISSUE) begin
      rob_pend_d  = rob_pend_q  && !rob_ready_i;
      ar_pend_d   = ar_pend_q   && !ar_ready_i;
      wb_pend_d   = wb_pend_q   && !wb_ready_i;
      fill_pend_d = fill_pend_q && !fill_ready_i;
    end
  end

  assign issue_done = !(rob_pend_q && !rob_ready_i) && !(ar_pend_q && !ar_ready_i) &&
                      !(wb_pend_q && !wb_ready_i) && !(fill_pend_q && !fill_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid_i && meta_valid_i) state_d = S_CMP;
      S_CMP:   state_d = S_ISSUE;
      S_ISSUE: if (issue_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // Gated by rst_n so both readies are low for the whole reset.
    req_ready_o    = rst_n && (state_q == S_IDLE);
    meta_ready_o   = rst_n && (state_q == S_IDLE);
    rob_valid_o    = rob_pend_q;
    ar_valid_o     = ar_pend_q;
    wb_valid_o     = wb_pend_q;
    fill_valid_o   = fill_pend_q;
    rob_data_o     = rob_data_q;
    ar_data_o      = ar_data_q;
    wb_data_o      = wb_data_q;
    fill_data_o    = fill_data_q;
    hit_cnt_o      = hit_cnt_q;
    miss_cnt_o     = miss_cnt_q;
    multihit_err_o = multihit_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q     <= 1'b0;
      tid_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      meta_q      <= '0;
      line_q      <= '0;
      rob_pend_q  <= 1'b0;
      ar_pend_q   <= 1'b0;
      wb_pend_q   <= 1'b0;
      fill_pend_q <= 1'b0;
      rob_data_q  <= '0;
      ar_data_q   <= '0;
      wb_data_q   <= '0;
      fill_data_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      multihit_q  <= 1'b0;
    end else begin
      write_q     <= write_d;
      tid_q       <= tid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      meta_q      <= meta_d;
      line_q      <= line_d;
      rob_pend_q  <= rob_pend_d;
      ar_pend_q   <= ar_pend_d;
      wb_pend_q   <= wb_pend_d;
      fill_pend_q <= fill_pend_d;
      rob_data_q  <= rob_data_d;
      ar_data_q   <= ar_data_d;
      wb_data_q   <= wb_data_d;
      fill_data_q <= fill_data_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      multihit_q  <= multihit_d;
    end
  end

endmodule

// File: tb/tb_tag_compare_assoc.sv
// Bench for tag_compare_assoc with the default 4-way geometry
// (32-bit address, 6 index bits, 4 offset bits -> 22-bit tag).
module tb_tag_compare_assoc;

  localparam int AW = 32, DW = 32, TW = 4, IW = 6, OW = 4, NW = 4;
  localparam int TAGW = AW - IW - OW;
  localparam int MW = TAGW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid_i = 1'b0, req_write_i = 1'b0, meta_valid_i = 1'b0;
  logic [TW-1:0] req_tid_i = '0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic [NW*MW-1:0] meta_i = '0;
  logic [NW*DW-1:0] line_i = '0;
  logic req_ready_o, meta_ready_o;
  logic rob_valid_o, ar_valid_o, wb_valid_o, fill_valid_o;
  logic rob_ready_i = 1'b0, ar_ready_i = 1'b0, wb_ready_i = 1'b0, fill_ready_i = 1'b0;
  logic [TW+DW-1:0] rob_data_o;
  logic [TW+AW-1:0] ar_data_o;
  logic [AW+DW-1:0] wb_data_o;
  logic [AW+2+DW:0] fill_data_o;
  logic [31:0] hit_cnt_o, miss_cnt_o;
  logic multihit_err_o;

  tag_compare_assoc #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TID_WIDTH(TW),
    .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .WAYS(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_tid_i(req_tid_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .meta_valid_i(meta_valid_i), .meta_ready_o(meta_ready_o),
    .meta_i(meta_i), .line_i(line_i),
    .rob_valid_o(rob_valid_o), .rob_ready_i(rob_ready_i), .rob_data_o(rob_data_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_data_o(ar_data_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .fill_valid_o(fill_valid_o), .fill_ready_i(fill_ready_i), .fill_data_o(fill_data_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .multihit_err_o(multihit_err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int      rr_m = 0;
  longint  hits_m = 0, misses_m = 0;
  bit      mh_m = 0;

  // Per-transaction stimulus: way contents and per-channel ready delays
  // (channel order: 0 rob, 1 ar, 2 wb, 3 fill)
  bit              m_v[NW], m_d[NW];
  logic [TAGW-1:0] m_tag[NW];
  logic [DW-1:0]   m_line[NW];
  int              dly[4];
  string           ch_name[4] = '{"rob", "ar", "wb", "fill"};
  logic [TAGW-1:0] pool[4] = '{22'h12, 22'h3ABCD, 22'h15555, 22'h0};

  task automatic set_way(input int w, input bit v, input bit d,
                         input logic [TAGW-1:0] t, input logic [DW-1:0] l);
    m_v[w] = v; m_d[w] = d; m_tag[w] = t; m_line[w] = l;
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_hit_cnt"}, hit_cnt_o, hits_m);
    check_eq({tag, "_miss_cnt"}, miss_cnt_o, misses_m);
    check_eq({tag, "_multihit"}, multihit_err_o, mh_m);
  endtask

  task automatic model_reset();
    rr_m = 0; hits_m = 0; misses_m = 0; mh_m = 0;
  endtask

  // One complete request; abort_at >= 0 asserts reset in that issue cycle.
  task automatic do_txn(input bit wr, input logic [TW-1:0] tid, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int abort_at);
    logic [TAGW-1:0] tag;
    logic [IW-1:0]   idx;
    logic [1:0]      wsel;
    logic [127:0]    expd[4];
    bit              raise[4];
    bit              got_v[4];
    logic [127:0]    got_d[4];
    bit              rdy;
    int hway, vic, hc, maxd;

    tag = addr[AW-1:IW+OW];
    idx = addr[IW+OW-1:OW];
    hc = 0; hway = -1;
    for (int w = 0; w < NW; w++)
      if (m_v[w] && m_tag[w] == tag) begin
        hc++;
        if (hway < 0) hway = w;
      end
    if (hc > 1) mh_m = 1;
    vic = -1;
    for (int w = NW - 1; w >= 0; w--) if (!m_v[w]) vic = w;
    for (int c = 0; c < 4; c++) begin raise[c] = 0; expd[c] = '0; end
    if (hc > 0) begin
      hits_m++;
      wsel = hway[1:0];
      if (wr) begin raise[3] = 1; expd[3] = {addr, wsel, wd, 1'b1}; end
      else    begin raise[0] = 1; expd[0] = {tid, m_line[hway]}; end
    end else begin
      misses_m++;
      if (vic < 0) begin vic = rr_m; rr_m = (rr_m + 1) % NW; end
      wsel = vic[1:0];
      if (wr) begin raise[3] = 1; expd[3] = {addr, wsel, wd, 1'b1}; end
      else    begin raise[1] = 1; expd[1] = {tid, addr[AW-1:OW], 4'h0}; end
      if (m_v[vic] && m_d[vic]) begin
        raise[2] = 1;
        expd[2] = {m_tag[vic], idx, 4'h0, m_line[vic]};
      end
    end
    maxd = 0;
    for (int c = 0; c < 4; c++) if (raise[c] && dly[c] > maxd) maxd = dly[c];

    @(negedge clk);
    check_eq("idle_req_ready", req_ready_o, 1'b1);
    check_eq("idle_meta_ready", meta_ready_o, 1'b1);
    for (int w = 0; w < NW; w++) begin
      meta_i[w*MW +: MW] = {m_v[w], m_d[w], m_tag[w]};
      line_i[w*DW +: DW] = m_line[w];
    end
    req_write_i = wr; req_tid_i = tid; req_addr_i = addr; req_wdata_i = wd;
    if ($urandom_range(0, 3) == 0) begin
      // Only one of the two valids: must not be accepted.
      if ($urandom_range(0, 1) == 0) req_valid_i = 1'b1; else meta_valid_i = 1'b1;
      @(negedge clk);
      check_eq("single_valid_stays_idle", req_ready_o, 1'b1);
    end
    req_valid_i = 1'b1; meta_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0; meta_valid_i = 1'b0;
    // Scramble inputs: the block must work from captured copies.
    meta_i = {$urandom, $urandom, $urandom};
    line_i = {$urandom, $urandom, $urandom, $urandom};
    req_addr_i = $urandom; req_wdata_i = $urandom; req_write_i = ~wr;
    check_eq("cmp_not_ready", req_ready_o, 1'b0);

    for (int k = 0; k <= maxd; k++) begin
      @(negedge clk);
      got_v = '{rob_valid_o, ar_valid_o, wb_valid_o, fill_valid_o};
      got_d = '{rob_data_o, ar_data_o, wb_data_o, fill_data_o};
      for (int c = 0; c < 4; c++) begin
        check_eq($sformatf("%s_valid_k%0d", ch_name[c], k), got_v[c], raise[c] && k <= dly[c]);
        if (raise[c] && k <= dly[c])
          check_eq($sformatf("%s_data_k%0d", ch_name[c], k), got_d[c], expd[c]);
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_valids", {rob_valid_o, ar_valid_o, wb_valid_o, fill_valid_o}, 4'b0);
        check_eq("rst_data_zero", |{rob_data_o, ar_data_o, wb_data_o, fill_data_o}, 1'b0);
        check_eq("rst_readies", {req_ready_o, meta_ready_o}, 2'b00);
        model_reset();
        check_counters("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_readies", {req_ready_o, meta_ready_o}, 2'b11);
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check_eq("post_rst_no_valid", {rob_valid_o, ar_valid_o, wb_valid_o, fill_valid_o}, 4'b0);
        end
        return;
      end
      for (int c = 0; c < 4; c++) begin
        rdy = raise[c] ? (k >= dly[c]) : 1'($urandom_range(0, 1));
        case (c)
          0: rob_ready_i = rdy;
          1: ar_ready_i = rdy;
          2: wb_ready_i = rdy;
          default: fill_ready_i = rdy;
        endcase
      end
    end
    @(negedge clk);
    check_eq("back_to_idle", req_ready_o, 1'b1);
    check_eq("idle_valids", {rob_valid_o, ar_valid_o, wb_valid_o, fill_valid_o}, 4'b0);
    check_counters("txn");
  endtask

  task automatic random_txn();
    bit allv;
    logic [9:0] lo;
    logic [TAGW-1:0] t;
    allv = 1'($urandom_range(0, 1));
    for (int w = 0; w < NW; w++) begin
      m_v[w] = allv ? 1'b1 : ($urandom_range(0, 3) != 0);
      m_d[w] = m_v[w] & 1'($urandom_range(0, 1));
      m_tag[w] = pool[$urandom_range(0, 3)];
      m_line[w] = $urandom;
    end
    for (int c = 0; c < 4; c++) dly[c] = $urandom_range(0, 3);
    lo = 10'($urandom);
    t = pool[$urandom_range(0, 3)];
    do_txn(1'($urandom_range(0, 1)), 4'($urandom), {t, lo}, $urandom, -1);
  endtask

  initial begin
    #1;
    check_eq("reset_readies", {req_ready_o, meta_ready_o}, 2'b00);
    check_eq("reset_valids", {rob_valid_o, ar_valid_o, wb_valid_o, fill_valid_o}, 4'b0);
    check_eq("reset_data_zero", |{rob_data_o, ar_data_o, wb_data_o, fill_data_o}, 1'b0);
    check_counters("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("first_cycle_ready", {req_ready_o, meta_ready_o}, 2'b11);

    for (int c = 0; c < 4; c++) dly[c] = 0;

    // Read hit in way 2
    set_way(0, 0, 0, 22'h12, 32'h1111_0000);
    set_way(1, 1, 0, 22'h5,  32'h1111_0001);
    set_way(2, 1, 0, 22'h12, 32'hCAFE_0002);
    set_way(3, 0, 0, 22'h0,  32'h1111_0003);
    do_txn(1'b0, 4'h3, {22'h12, 6'h05, 4'h8}, 32'h0, -1);
    check_eq("d1_hit_cnt_one", hit_cnt_o, 32'd1);

    // Read miss, all valid, way0 dirty, pointer 0
    set_way(0, 1, 1, 22'h1, 32'hD0D0_0000);
    set_way(1, 1, 0, 22'h2, 32'hD0D0_0001);
    set_way(2, 1, 0, 22'h3, 32'hD0D0_0002);
    set_way(3, 1, 0, 22'h4, 32'hD0D0_0003);
    do_txn(1'b0, 4'h7, {22'h12, 6'h2A, 4'h4}, 32'h0, -1);

    // Write miss with way1 invalid: fill way 1, no writeback
    set_way(0, 1, 1, 22'h7, 32'h2222_0000);
    set_way(1, 0, 0, 22'h8, 32'h2222_0001);
    set_way(2, 1, 1, 22'h9, 32'h2222_0002);
    set_way(3, 1, 1, 22'hA, 32'h2222_0003);
    do_txn(1'b1, 4'h1, {22'h99, 6'h11, 4'h0}, 32'hBEEF_1234, -1);

    // Read miss, ar stalled 5 cycles, wb ready immediately (pointer now 1)
    for (int w = 0; w < NW; w++) set_way(w, 1, 1, 22'h20 + 22'(w), 32'h3333_0000 + 32'(w));
    dly = '{0, 5, 0, 0};
    do_txn(1'b0, 4'h9, {22'h77, 6'h3F, 4'hC}, 32'h0, -1);

    // Two ways hit: lowest way wins, sticky error
    dly = '{0, 0, 0, 0};
    set_way(0, 0, 0, 22'h12, 32'h4444_0000);
    set_way(1, 1, 0, 22'h12, 32'h4444_0001);
    set_way(2, 0, 0, 22'h0,  32'h4444_0002);
    set_way(3, 1, 1, 22'h12, 32'h4444_0003);
    do_txn(1'b0, 4'h5, {22'h12, 6'h00, 4'h0}, 32'h0, -1);

    for (int i = 0; i < 150; i++) random_txn();

    // Reset while ar/wb are stalled in issue
    for (int w = 0; w < NW; w++) set_way(w, 1, 1, 22'h30 + 22'(w), 32'h5555_0000 + 32'(w));
    dly = '{0, 10, 10, 0};
    do_txn(1'b0, 4'h2, {22'h12, 6'h01, 4'h0}, 32'h0, 2);

    for (int i = 0; i < 30; i++) random_txn();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_compare_assoc.md
TAG_COMPARE_ASSOC -- requirements
Module: tag_compare_assoc

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_WIDTH, `AXI_ADDR_WIDTH: request address bits.
- DATA_WIDTH, `AXI_DATA_WIDTH: cache line data bits.
- TID_WIDTH, `TID_WIDTH: transaction id bits.
- INDEX_WIDTH, `INDEX_WIDTH: set index bits.
- OFFSET_WIDTH, `OFFSET_WIDTH: line offset bits.
- WAYS, 4: associativity; legal values 1, 2, 4, 8.
- TAG_WIDTH is derived as ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- req_valid_i / req_ready_o, in/out, 1: request handshake.
- req_write_i, in, 1: 0 = read, 1 = write.
- req_tid_i, in, TID_WIDTH: transaction id.
- req_addr_i, in, ADDR_WIDTH: request address.
- req_wdata_i, in, DATA_WIDTH: write data.
- meta_valid_i / meta_ready_o, in/out, 1: tag-read response handshake.
- meta_i, in, WAYS*(2+TAG_WIDTH): per way {valid, dirty, tag}; way 0 in the LSBs.
- line_i, in, WAYS*DATA_WIDTH: per-way line data.
- rob_valid_o / rob_ready_i, out/in, 1: read-hit data handshake.
- rob_data_o, out, TID_WIDTH+DATA_WIDTH: {tid, data}.
- ar_valid_o / ar_ready_i, out/in, 1: miss fetch request handshake.
- ar_data_o, out, TID_WIDTH+ADDR_WIDTH: {tid, line-aligned addr}.
- wb_valid_o / wb_ready_i, out/in, 1: dirty-victim writeback handshake.
- wb_data_o, out, ADDR_WIDTH+DATA_WIDTH: {victim addr, victim data}.
- fill_valid_o / fill_ready_i, out/in, 1: cache update handshake.
- fill_data_o, out, ADDR_WIDTH+log2(WAYS)+DATA_WIDTH+1: {addr, way, data, dirty}.
- hit_cnt_o, out, 32: hit count.
- miss_cnt_o, out, 32: miss count.
- multihit_err_o, out, 1: sticky multi-hit error flag.

Function
REQ-003 SHALL use an FSM with states S_IDLE, S_CMP, S_ISSUE.
REQ-004 S_IDLE SHALL assert req_ready_o and meta_ready_o together, and SHALL accept a request only when req_valid_i and meta_valid_i are both 1 in the same cycle; it then captures all inputs and moves to S_CMP.
REQ-005 S_CMP SHALL take exactly one cycle and compute, per way, hit[w] = valid[w] && tag[w] == addr tag field.
REQ-006 If more than one hit bit is set, the lowest-numbered hitting way SHALL win and multihit_err_o SHALL set until reset.
REQ-007 Victim selection on a miss SHALL pick the lowest-numbered invalid way; if every way is valid, it SHALL pick the round-robin pointer way.
REQ-008 The round-robin pointer SHALL advance by 1, modulo WAYS, on each miss where all ways were valid, and wraps from WAYS-1 to 0.
REQ-009 Outputs raised in S_ISSUE SHALL depend on the request type:
- Read hit: rob only.
- Read miss: ar, plus wb when the victim is dirty.
- Write hit: fill with dirty=1 at the hit way.
- Write miss: fill with dirty=1 at the victim way, plus wb when the victim is dirty.
REQ-010 Writeback address SHALL be {victim tag, captured index, OFFSET_WIDTH zeros}.
REQ-011 A clean victim SHALL never raise wb_valid_o.
REQ-012 S_ISSUE SHALL hold each raised valid, with stable data, until its own ready is seen; each channel completes independently, including completions in the same cycle.
REQ-013 S_ISSUE SHALL return to S_IDLE in the cycle after the last pending channel completes.
REQ-014 Best-case request-to-request throughput SHALL be one request per 3 cycles (S_IDLE, S_CMP, S_ISSUE each one cycle when ready is already high).
REQ-015 hit_cnt_o and miss_cnt_o SHALL increment by 1 in S_CMP and saturate at 0xFFFF_FFFF.
REQ-016 With WAYS=1, behaviour SHALL reduce to direct-mapped, with the victim always way 0.

Reset
REQ-017 While rst_n=0, the block SHALL drive:
- state = S_IDLE;
- all *_valid_o = 0;
- all data outputs = 0;
- counters = 0;
- multihit_err_o = 0;
- round-robin pointer = 0;
- req_ready_o and meta_ready_o = 0.
REQ-018 Reset asserted mid-transaction SHALL abandon the transaction, with no further valid pulses after rst_n deasserts.
REQ-019 The first cycle after rst_n deasserts SHALL be S_IDLE with both ready signals at 1.

Structure
REQ-020 The shared package (AXI_TYPEDEF.svh) SHALL hold the WAYS default, the metadata field layout macros (VALID/DIRTY/TAG positions), and the state encoding.
REQ-021 Hit detection and victim selection SHALL be a sub-module, way_select: combinational priority encoder plus round-robin register, parametrised by WAYS and TAG_WIDTH.

Verification
REQ-022 Directed scenarios, each as stimulus -> required response:
- WAYS=4, read addr tag 0x12, way2 {v=1, tag 0x12} -> single rob beat carrying tid and line_i way2; hit_cnt=1.
- Read miss, all ways valid, way0 dirty, pointer 0 -> ar {tid, addr} and wb {way0 tag addr, way0 data}; pointer becomes 1.
- Write miss, way1 invalid -> fill way=1 dirty=1; no wb.
- Read miss with ar_ready_i held 0 for 5 cycles while wb_ready_i is 1 -> wb completes at once; ar holds stable, completes on cycle 6, then S_IDLE.
- Two ways hit the same tag -> lowest way used; multihit_err_o=1 until rst_n asserted.
- rst_n asserted during S_ISSUE -> all valids 0 within the same cycle; counters 0.
